// File: rtl/uart1_rx_status.sv
// UART1 receive front-end: 2-flop input synchroniser, 8N1 deserialiser, 8-entry show-ahead
// receive FIFO, sticky error flags and the registered 10-bit status word read by the CPU.
module uart1_rx_status #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       pop,
    input  logic       clear_errors,
    output logic [7:0] rx_data,
    output logic [9:0] status
);

    localparam int            CW      = 12;
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CT = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CT = CW'(CLKS_PER_BIT / 2);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           push_q, push_d;
    logic           rxd_meta, rxd_s, rxd_prev;
    logic           frame_set, brk_set, expire;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [AW:0]    count, count_d;
    logic           full, empty, push_ok, pop_ok, ovr_set, load_head;
    logic           ovr_q, frame_q, brk_q;

    // Idle-high line: synchroniser resets to 1 so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value of its source.
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            push_q  <= push_d;
        end
    end

    assign expire = (cnt_q == CW'(1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        frame_set = 1'b0;
        brk_set   = 1'b0;
        if (state_q inside {START, DATA, STOP} && !expire) cnt_d = cnt_q - 1'b1;
        unique case (state_q)
            IDLE: begin
                if (rxd_prev && !rxd_s) begin
                    cnt_d   = HALF_CT;
                    state_d = START;
                end
            end
            START: begin
                if (expire) begin
                    if (rxd_s) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = FULL_CT;
                        bit_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d = {rxd_s, shift_q[7:1]};
                    cnt_d   = FULL_CT;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end
            end
            STOP: begin
                if (expire) begin
                    if (rxd_s) begin
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        brk_set   = (shift_q == 8'h00);
                        state_d   = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A push into a full FIFO survives only when a pop frees the head slot in the same cycle.
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push_q && (!full || pop_ok);
    assign ovr_set = push_q && full && !pop_ok;

    always_comb begin
        count_d = count;
        if (push_ok && !pop_ok)      count_d = count + 1'b1;
        else if (pop_ok && !push_ok) count_d = count - 1'b1;
    end

    // NOTE: the data array has no reset; rx_data only ever shows entries that have been written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            load_head <= 1'b0;
            rx_data   <= 8'h00;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_d;
            load_head <= (push_ok && empty) || (pop_ok && count_d != '0);
            if (load_head) rx_data <= mem[rd_ptr];
        end
    end

    // Sticky flags: a set in the same cycle as clear_errors wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_q   <= 1'b0;
            frame_q <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            ovr_q   <= ovr_set   || (ovr_q   && !clear_errors);
            frame_q <= frame_set || (frame_q && !clear_errors);
            brk_q   <= brk_set   || (brk_q   && !clear_errors);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) status <= 10'h010;
        else          status <= {state_q != IDLE, brk_q, frame_q, ovr_q, full, empty, count};
    end

endmodule

// File: tb/tb_uart1_rx_status.sv
// Randomised bench for uart1_rx_status: a byte-level model (FIFO queue, flags, busy windows)
// predicts status and rx_data every cycle, with literal checks pinning the model.
module tb_uart1_rx_status;

    localparam int CPB       = 16;
    localparam int START_DLY = 3;                           // rxd edge -> FSM leaves IDLE
    localparam int STOP_SMP  = START_DLY + CPB / 2 + 9 * CPB; // rxd edge -> stop-bit sample edge
    localparam int FRAME_LEN = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       pop = 1'b0;
    logic       clear_errors = 1'b0;
    logic [7:0] rx_data;
    logic [9:0] status;

    uart1_rx_status #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rxd          (rxd),
        .pop          (pop),
        .clear_errors (clear_errors),
        .rx_data      (rx_data),
        .status       (status)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_ON, EV_OFF, EV_PUSH, EV_FRM, EV_BRK} ev_kind_t;
    typedef struct {
        int         cyc;
        int         made;
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    ev_t        ev_q[$];
    logic [7:0] m_fifo[$];
    bit         m_busy = 0, m_ovr = 0, m_frm = 0, m_brk = 0;
    int         last_reset = 0;
    logic [9:0] exp_status = 10'h010;
    logic [7:0] exp_rx = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic sched(input int c, input ev_kind_t kind, input logic [7:0] d);
        ev_t e;
        e.cyc  = c;
        e.made = cyc;
        e.kind = kind;
        e.data = d;
        ev_q.push_back(e);
    endtask

    // Model: status after edge n shows the FIFO/flag/busy state that held after edge n-1.
    initial forever begin
        bit       do_push, set_ovr, set_frm, set_brk, pop_eff;
        logic [7:0] pdata;
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            m_fifo.delete();
            {m_busy, m_ovr, m_frm, m_brk} = '0;
            exp_status = 10'h010;
            exp_rx     = 8'h00;
            last_reset = cyc;
        end else begin
            exp_status = {m_busy, m_brk, m_frm, m_ovr, m_fifo.size() == 8,
                          m_fifo.size() == 0, 4'(m_fifo.size())};
            if (m_fifo.size() > 0) exp_rx = m_fifo[0];
            {do_push, set_ovr, set_frm, set_brk} = '0;
            pdata = 8'h00;
            foreach (ev_q[i]) begin
                if (ev_q[i].cyc == cyc && ev_q[i].made > last_reset) begin
                    case (ev_q[i].kind)
                        EV_ON:   m_busy = 1'b1;
                        EV_OFF:  m_busy = 1'b0;
                        EV_PUSH: begin do_push = 1'b1; pdata = ev_q[i].data; end
                        EV_FRM:  set_frm = 1'b1;
                        EV_BRK:  set_brk = 1'b1;
                        default: ;
                    endcase
                end
            end
            pop_eff = pop && m_fifo.size() > 0;
            if (pop_eff) void'(m_fifo.pop_front());
            if (do_push) begin
                if (m_fifo.size() < 8) m_fifo.push_back(pdata);
                else                   set_ovr = 1'b1;
            end
            m_ovr = set_ovr || (m_ovr && !clear_errors);
            m_frm = set_frm || (m_frm && !clear_errors);
            m_brk = set_brk || (m_brk && !clear_errors);
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            check("model_status", status, exp_status);
            check("model_rx_data", rx_data, exp_rx);
        end
    end

    // One 8N1 frame starting now, then `gap` idle cycles; pop/clear either random or at fixed offsets.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int gap, input bit rnd,
                              input int pop_at, input int clr_at);
        int n;
        int idx;
        n = cyc;
        sched(n + START_DLY, EV_ON, 8'h00);
        if (stop_ok) begin
            sched(n + STOP_SMP, EV_OFF, 8'h00);
            sched(n + STOP_SMP + 1, EV_PUSH, d);
        end else begin
            sched(n + STOP_SMP, EV_FRM, 8'h00);
            if (d == 8'h00) sched(n + STOP_SMP, EV_BRK, 8'h00);
            sched(n + FRAME_LEN + START_DLY, EV_OFF, 8'h00);
        end
        for (int c = 0; c < FRAME_LEN + gap; c++) begin
            idx = c / CPB;
            if (idx == 0)      rxd = 1'b0;
            else if (idx <= 8) rxd = d[idx-1];
            else if (idx == 9) rxd = stop_ok;
            else               rxd = 1'b1;
            if (rnd) begin
                pop          = ($urandom_range(0, 199) == 0);
                clear_errors = ($urandom_range(0, 299) == 0);
            end else begin
                pop          = (c == pop_at);
                clear_errors = (c == clr_at);
            end
            tick(1);
        end
        pop = 1'b0;
        clear_errors = 1'b0;
    endtask

    task automatic pop_one();
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        tick(1);
    endtask

    task automatic clear_one();
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int         n;
        logic [7:0] d;
        tick(5);
        check("reset_status", status, 10'h010);
        check("reset_rx_data", rx_data, 8'h00);
        reset_n = 1'b1;
        tick(3);
        check("post_reset_status", status, 10'h010);

        // Single byte, then pop.
        send_frame(8'hA5, 1'b1, 4, 1'b0, -1, -1);
        check("single_status", status, 10'h001);
        check("single_rx_data", rx_data, 8'hA5);
        pop_one();
        check("single_pop_status", status, 10'h010);
        check("single_hold_rx_data", rx_data, 8'hA5);

        // False start: 6 cycles low.
        n = cyc;
        sched(n + START_DLY, EV_ON, 8'h00);
        sched(n + START_DLY + CPB / 2, EV_OFF, 8'h00);
        rxd = 1'b0;
        tick(6);
        check("false_start_active", status[9], 1'b1);
        rxd = 1'b1;
        tick(20);
        check("false_start_status", status, 10'h010);

        // Overrun: nine bytes, no pops.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 4, 1'b0, -1, -1);
        check("overrun_status", status, 10'h068);
        for (int i = 1; i <= 8; i++) begin
            check("overrun_rx_data", rx_data, 32'(i));
            pop_one();
        end
        check("overrun_drained", status, 10'h050);
        clear_one();
        check("overrun_cleared", status, 10'h010);

        // Framing error, then a held break.
        send_frame(8'h3C, 1'b0, 4, 1'b0, -1, -1);
        check("framing_status", status, 10'h090);
        clear_one();
        n = cyc;
        sched(n + START_DLY, EV_ON, 8'h00);
        sched(n + STOP_SMP, EV_FRM, 8'h00);
        sched(n + STOP_SMP, EV_BRK, 8'h00);
        rxd = 1'b0;
        tick(600);
        check("break_wait_idle", status[9], 1'b1);
        tick(40 * CPB - 600);
        sched(cyc + START_DLY, EV_OFF, 8'h00);
        rxd = 1'b1;
        tick(6);
        check("break_status", status, 10'h190);
        send_frame(8'h55, 1'b1, 4, 1'b0, -1, -1);
        check("after_break_status", status, 10'h181);
        check("after_break_rx_data", rx_data, 8'h55);
        pop_one();

        // Clear colliding with a new framing detect: framing stays, break and overrun clear.
        send_frame(8'h12, 1'b0, 4, 1'b0, -1, STOP_SMP - 1);
        check("clear_collision", status, 10'h090);
        clear_one();
        check("clear_alone", status, 10'h010);

        // Reset during data bit 4.
        n = cyc;
        sched(n + START_DLY, EV_ON, 8'h00);
        d = 8'hF0;
        for (int c = 0; c < 5 * CPB + CPB / 2; c++) begin
            rxd = (c < CPB) ? 1'b0 : d[c/CPB-1];
            tick(1);
        end
        check("mid_frame_active", status[9], 1'b1);
        reset_n = 1'b0;
        rxd = 1'b1;
        #1;
        check("mid_reset_status", status, 10'h010);
        check("mid_reset_rx_data", rx_data, 8'h00);
        tick(4);
        reset_n = 1'b1;
        tick(10);
        send_frame(8'hC3, 1'b1, 4, 1'b0, -1, -1);
        check("c3_status", status, 10'h001);
        check("c3_rx_data", rx_data, 8'hC3);

        // Full FIFO with a pop in the push cycle.
        for (int i = 1; i <= 7; i++) send_frame(8'h80 + 8'(i), 1'b1, 4, 1'b0, -1, -1);
        check("full_status", status, 10'h028);
        send_frame(8'hEE, 1'b1, 4, 1'b0, STOP_SMP, -1);
        check("full_push_pop_status", status, 10'h028);
        check("full_push_pop_rx_data", rx_data, 8'h81);
        for (int i = 1; i <= 8; i++) begin
            check("full_drain_rx_data", rx_data, (i == 8) ? 32'hEE : 32'h80 + 32'(i));
            pop_one();
        end
        check("full_drained", status, 10'h010);

        // Random frames with random pops and clears; the model checks every cycle.
        for (int k = 0; k < 20; k++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 9) == 0) d = 8'h00;
            send_frame(d, $urandom_range(0, 4) != 0, $urandom_range(4, 20), 1'b1, -1, -1);
        end
        for (int i = 0; i < 8; i++) if (!status[4]) pop_one();
        check("random_drained", status[4], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
